// File: rtl/lia_demod_integrator.sv
// Sample-synchronous I/Q lock-in demodulator.
// The NCO steps once per accepted ADC sample; sin/cos products are summed with
// saturation over a programmable block length and then dumped to i_out/q_out.
// Handshake: adc_valid has no ready; a sample is consumed on every rising edge
// where adc_valid is high and cfg_load is low. out_valid is a one-cycle pulse
// with no backpressure. i_out/q_out hold until the next dump.
// The sine table is computed at elaboration by a constant function, so the
// design carries no external memory-image dependency.
module lia_demod_integrator #(
  parameter int DATA_WIDTH     = 12,
  parameter int NCO_WIDTH      = 12,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int DECIM_WIDTH    = 16,
  parameter int ACC_WIDTH      = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_load,
  input  logic [PHASE_WIDTH-1:0]        phase_increment,
  input  logic [PHASE_WIDTH-1:0]        phase_offset,
  input  logic [DECIM_WIDTH-1:0]        decim_len,
  input  logic signed [DATA_WIDTH-1:0]  adc_data,
  input  logic                          adc_valid,
  output logic signed [ACC_WIDTH-1:0]   i_out,
  output logic signed [ACC_WIDTH-1:0]   q_out,
  output logic                          out_valid,
  output logic                          overflow
);

  localparam int     PROD_WIDTH = DATA_WIDTH + NCO_WIDTH;
  localparam int     DEPTH      = 1 << LUT_ADDR_WIDTH;
  localparam int     QUARTER    = DEPTH / 4;
  localparam longint PI_Q30     = 64'sd3373259426;

  // Full-wave table of round(A*sin(2*pi*k/DEPTH)), A = 2**(NCO_WIDTH-1)-1.
  // The first quadrant is evaluated by a Q30 Taylor series and mirrored.
  function automatic logic [DEPTH*NCO_WIDTH-1:0] build_lut();
    logic [DEPTH*NCO_WIDTH-1:0] table_bits;
    longint x, x2, term, acc, amp, mag;
    int m;
    table_bits = '0;
    amp = (longint'(1) << (NCO_WIDTH - 1)) - 1;
    for (int k = 0; k < DEPTH; k++) begin
      m = k % QUARTER;
      if (((k / QUARTER) % 2) == 1) m = QUARTER - m;
      x    = (PI_Q30 * longint'(m)) / longint'(2 * QUARTER);
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 10; n++) begin
        term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
        acc  = acc + term;
      end
      mag = (acc * amp + (longint'(1) << 29)) >>> 30;
      if (k >= DEPTH / 2) mag = -mag;
      table_bits[k*NCO_WIDTH +: NCO_WIDTH] = NCO_WIDTH'(mag);
    end
    return table_bits;
  endfunction

  localparam logic [DEPTH*NCO_WIDTH-1:0] LUT_BITS = build_lut();

  // Saturate a one-bit-wider sum back into the signed accumulator range.
  function automatic logic [ACC_WIDTH-1:0] saturate(input logic [ACC_WIDTH:0] s);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
  endfunction

  logic [PHASE_WIDTH-1:0]        inc_r, off_r, phase_accum;
  logic [DECIM_WIDTH-1:0]        len_r, cnt;
  logic [LUT_ADDR_WIDTH-1:0]     sin_addr_c, cos_addr_c, sin_addr0, cos_addr0;
  logic signed [DATA_WIDTH-1:0]  adc0, adc_r;
  logic signed [NCO_WIDTH-1:0]   sin_r, cos_r;
  logic signed [PROD_WIDTH-1:0]  adc_ext, sin_ext, cos_ext, prod_i, prod_q;
  logic [ACC_WIDTH-1:0]          acc_i, acc_q, sat_i, sat_q;
  logic [ACC_WIDTH:0]            sum_i_w, sum_q_w;
  logic                          v0, v1, v2, ovf_i, ovf_q;

  // Reference phase = accumulator + offset (mod 2**PHASE_WIDTH); cos leads sin by a quarter wave.
  assign sin_addr_c = LUT_ADDR_WIDTH'((phase_accum + off_r) >> (PHASE_WIDTH - LUT_ADDR_WIDTH));
  assign cos_addr_c = sin_addr_c + LUT_ADDR_WIDTH'(QUARTER);

  assign adc_ext = {{NCO_WIDTH{adc_r[DATA_WIDTH-1]}}, adc_r};
  assign sin_ext = {{DATA_WIDTH{sin_r[NCO_WIDTH-1]}}, sin_r};
  assign cos_ext = {{DATA_WIDTH{cos_r[NCO_WIDTH-1]}}, cos_r};

  assign sum_i_w = {acc_i[ACC_WIDTH-1], acc_i} + {{(ACC_WIDTH+1-PROD_WIDTH){prod_i[PROD_WIDTH-1]}}, prod_i};
  assign sum_q_w = {acc_q[ACC_WIDTH-1], acc_q} + {{(ACC_WIDTH+1-PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
  assign ovf_i   = sum_i_w[ACC_WIDTH] != sum_i_w[ACC_WIDTH-1];
  assign ovf_q   = sum_q_w[ACC_WIDTH] != sum_q_w[ACC_WIDTH-1];
  assign sat_i   = saturate(sum_i_w);
  assign sat_q   = saturate(sum_q_w);

  // Configuration latch; a zero block length behaves as one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_r <= '0;
      off_r <= '0;
      len_r <= DECIM_WIDTH'(1);
    end else if (cfg_load) begin
      inc_r <= phase_increment;
      off_r <= phase_offset;
      len_r <= (decim_len == '0) ? DECIM_WIDTH'(1) : decim_len;
    end
  end

  // Stage 0: take the sample, register LUT addresses, advance the NCO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_accum <= '0;
      sin_addr0   <= '0;
      cos_addr0   <= '0;
      adc0        <= '0;
      v0          <= 1'b0;
    end else if (cfg_load) begin
      phase_accum <= '0;
      v0          <= 1'b0;
    end else begin
      v0 <= adc_valid;
      if (adc_valid) begin
        phase_accum <= phase_accum + inc_r;
        sin_addr0   <= sin_addr_c;
        cos_addr0   <= cos_addr_c;
        adc0        <= adc_data;
      end
    end
  end

  // Stage 1: registered ROM reads alongside the delayed sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_r <= '0;
      cos_r <= '0;
      adc_r <= '0;
      v1    <= 1'b0;
    end else begin
      sin_r <= LUT_BITS[int'(sin_addr0)*NCO_WIDTH +: NCO_WIDTH];
      cos_r <= LUT_BITS[int'(cos_addr0)*NCO_WIDTH +: NCO_WIDTH];
      adc_r <= adc0;
      v1    <= v0 & ~cfg_load;
    end
  end

  // Stage 2: full-precision signed products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_i <= '0;
      prod_q <= '0;
      v2     <= 1'b0;
    end else begin
      prod_i <= adc_ext * sin_ext;
      prod_q <= adc_ext * cos_ext;
      v2     <= v1 & ~cfg_load;
    end
  end

  // Stage 3: saturating integrate, dump on the last product of a block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (cfg_load) begin
        acc_i    <= '0;
        acc_q    <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else if (v2) begin
        if (ovf_i || ovf_q) overflow <= 1'b1;
        if (cnt == len_r - DECIM_WIDTH'(1)) begin
          i_out     <= sat_i;
          q_out     <= sat_q;
          out_valid <= 1'b1;
          acc_i     <= '0;
          acc_q     <= '0;
          cnt       <= '0;
        end else begin
          acc_i <= sat_i;
          acc_q <= sat_q;
          cnt   <= cnt + DECIM_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lia_demod_integrator.sv
// Testbench for lia_demod_integrator: reference model with scoreboard queues,
// plus a narrow-accumulator instance for the saturation scenario.
module tb_lia_demod_integrator;

  localparam int DW = 12, PW = 32, LAW = 8, DECW = 16, AW = 40, SAW = 24;
  localparam real PI = 3.14159265358979323846;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  cfg_load;
  logic [PW-1:0]         phase_increment, phase_offset;
  logic [DECW-1:0]       decim_len;
  logic signed [DW-1:0]  adc_data;
  logic                  adc_valid;
  logic signed [AW-1:0]  i_out, q_out;
  logic                  out_valid, overflow;
  logic signed [SAW-1:0] sat_i_out, sat_q_out;
  logic                  sat_out_valid, sat_overflow;

  lia_demod_integrator dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .phase_increment(phase_increment), .phase_offset(phase_offset),
    .decim_len(decim_len), .adc_data(adc_data), .adc_valid(adc_valid),
    .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .overflow(overflow)
  );

  lia_demod_integrator #(.ACC_WIDTH(SAW)) dut_sat (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .phase_increment(phase_increment), .phase_offset(phase_offset),
    .decim_len(decim_len), .adc_data(adc_data), .adc_valid(adc_valid),
    .i_out(sat_i_out), .q_out(sat_q_out), .out_valid(sat_out_valid), .overflow(sat_overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rom[256];

  // Scoreboard
  logic [AW-1:0] exp_i_q[$];
  logic [AW-1:0] exp_q_q[$];
  int            exp_cyc_q[$];

  // Reference model state
  logic [PW-1:0] m_phase, m_inc, m_off;
  int            m_len, m_cnt;
  longint        m_acc_i, m_acc_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every dump must match the oldest expected block result.
  always @(negedge clk) begin
    logic [AW-1:0] ei, eq;
    int ec;
    if (!rst && out_valid) begin
      if (exp_i_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid at cycle %0d: i=%0d q=%0d, no block expected", cyc, i_out, q_out);
      end else begin
        ei = exp_i_q.pop_front();
        eq = exp_q_q.pop_front();
        ec = exp_cyc_q.pop_front();
        checks++;
        if (i_out !== ei) begin
          errors++;
          $display("FAIL dump_i: got %0d expected %0d", i_out, $signed(ei));
        end
        checks++;
        if (q_out !== eq) begin
          errors++;
          $display("FAIL dump_q: got %0d expected %0d", q_out, $signed(eq));
        end
        checks++;
        if (cyc !== ec) begin
          errors++;
          $display("FAIL dump_latency: out_valid at cycle %0d expected cycle %0d", cyc, ec);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      adc_data = DW'($urandom_range(0, 4095));
      step();
    end
  endtask

  task automatic model_reset(input logic [PW-1:0] inc, input logic [PW-1:0] off, input int len);
    m_inc   = inc;
    m_off   = off;
    m_len   = (len == 0) ? 1 : len;
    m_phase = '0;
    m_cnt   = 0;
    m_acc_i = 0;
    m_acc_q = 0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && exp_i_q.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_i_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d blocks outstanding, expected 0", exp_i_q.size());
      exp_i_q.delete(); exp_q_q.delete(); exp_cyc_q.delete();
    end
    step();
  endtask

  task automatic drive_cfg(input logic [PW-1:0] inc, input logic [PW-1:0] off,
                           input logic [DECW-1:0] len, input bit with_sample);
    wait_drain();
    phase_increment = inc;
    phase_offset    = off;
    decim_len       = len;
    cfg_load        = 1'b1;
    adc_valid       = with_sample;
    adc_data        = DW'($urandom_range(0, 4095));
    step();
    cfg_load  = 1'b0;
    adc_valid = 1'b0;
    model_reset(inc, off, int'(len));
  endtask

  task automatic drive_sample(input int adc);
    logic [PW-1:0] p;
    int sa, ca;
    p  = m_phase + m_off;
    sa = int'(p[PW-1:PW-LAW]);
    ca = (sa + 64) % 256;
    m_acc_i = m_acc_i + longint'(adc) * longint'(rom[sa]);
    m_acc_q = m_acc_q + longint'(adc) * longint'(rom[ca]);
    m_cnt++;
    if (m_cnt >= m_len) begin
      exp_i_q.push_back(m_acc_i[AW-1:0]);
      exp_q_q.push_back(m_acc_q[AW-1:0]);
      exp_cyc_q.push_back(cyc + 1 + 3);
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt   = 0;
    end
    m_phase   = m_phase + m_inc;
    adc_data  = adc[DW-1:0];
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
  endtask

  function automatic int rand_adc();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Scenarios
  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = DW'($urandom_range(0, 4095));
      step();
      checks++;
      if ({out_valid, overflow, i_out, q_out} !== '0) begin
        errors++;
        $display("FAIL reset_hold: ov=%0b of=%0b i=%0d q=%0d expected all 0", out_valid, overflow, i_out, q_out);
      end
    end
    adc_valid = 1'b0;
    rst = 1'b0;
    idle(10);
    checks++;
    if ({out_valid, overflow, i_out, q_out} !== '0) begin
      errors++;
      $display("FAIL reset_release: ov=%0b of=%0b i=%0d q=%0d expected all 0", out_valid, overflow, i_out, q_out);
    end
  endtask

  task automatic test_dc();
    drive_cfg(32'h0, 32'h0, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) drive_sample(100);
    wait_drain();
    checks++;
    if (i_out !== 40'sd0) begin
      errors++; $display("FAIL dc_i: got %0d expected 0", i_out);
    end
    checks++;
    if (q_out !== 40'sd818800) begin
      errors++; $display("FAIL dc_q: got %0d expected 818800", q_out);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL dc_overflow: got %0b expected 0", overflow);
    end
  endtask

  task automatic test_tone(input logic [PW-1:0] off);
    drive_cfg(32'h0400_0000, off, 16'd64, 1'b0);
    for (int k = 0; k < 64; k++) begin
      drive_sample(rom[4*k] >>> 1);
      idle($urandom_range(0, 2));
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    bit found;
    drive_cfg(32'h0, 32'h0, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) drive_sample(2047);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (sat_out_valid) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL sat_dump_timeout: no out_valid from narrow instance, expected one");
    end
    checks++;
    if (sat_q_out !== 24'sh7F_FFFF) begin
      errors++; $display("FAIL sat_q: got %0d expected 8388607", sat_q_out);
    end
    checks++;
    if (sat_i_out !== 24'sd0) begin
      errors++; $display("FAIL sat_i: got %0d expected 0", sat_i_out);
    end
    checks++;
    if (sat_overflow !== 1'b1) begin
      errors++; $display("FAIL sat_overflow_set: got %0b expected 1", sat_overflow);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL wide_overflow: got %0b expected 0", overflow);
    end
    wait_drain();
    drive_cfg(32'h0, 32'h0, 16'd4, 1'b0);
    checks++;
    if (sat_overflow !== 1'b0) begin
      errors++; $display("FAIL sat_overflow_clear: got %0b expected 0", sat_overflow);
    end
  endtask

  task automatic test_restart();
    bit seen;
    drive_cfg(32'h0800_0000, 32'h2000_0000, 16'd4, 1'b0);
    drive_sample(300);
    drive_sample(-700);
    drive_cfg(32'h0800_0000, 32'h2000_0000, 16'd4, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    step();
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL restart_no_dump: out_valid seen=%0b expected 0", seen);
    end
    drive_sample(300);
    drive_sample(-250);
    drive_sample(511);
    drive_sample(-1000);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    drive_cfg(32'h1000_3039, 32'h0, 16'd4, 1'b0);
    for (int i = 0; i < 12; i++) drive_sample(rand_adc());
    wait_drain();
  endtask

  task automatic test_wrap_len();
    drive_cfg(32'hFFFF_FFFF, 32'h0, 16'd0, 1'b0);
    for (int i = 0; i < 300; i++) drive_sample(rand_adc());
    wait_drain();
  endtask

  task automatic test_reset_mid_block();
    drive_cfg(32'h0400_0000, 32'h0, 16'd8, 1'b0);
    drive_sample(1234);
    drive_sample(-999);
    drive_sample(555);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, overflow, i_out, q_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_block: ov=%0b of=%0b i=%0d q=%0d expected all 0", out_valid, overflow, i_out, q_out);
    end
    step();
    step();
    model_reset(32'h0, 32'h0, 1);
    rst = 1'b0;
    step();
    drive_sample(77);
    drive_sample(-5);
    drive_sample(1000);
    wait_drain();
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    real v;
    for (int k = 0; k < 256; k++) begin
      v = 2047.0 * $sin(2.0 * PI * real'(k) / 256.0);
      rom[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    end
    cfg_load = 1'b0;
    phase_increment = '0;
    phase_offset = '0;
    decim_len = '0;
    adc_data = '0;
    adc_valid = 1'b0;
    model_reset(32'h0, 32'h0, 1);

    test_reset();
    test_dc();
    test_tone(32'h0);
    test_tone(32'h4000_0000);
    test_saturation();
    test_restart();
    test_back_to_back();
    test_wrap_len();
    test_reset_mid_block();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
